// File: rtl/duty_ramp_if.sv
// Target-duty command channel for duty_ramp: the source offers cmd_duty with
// cmd_valid and the ramp sequencer answers with cmd_ready.
interface duty_ramp_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_duty;

    modport master (output cmd_valid, output cmd_duty, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_duty, output cmd_ready);
endinterface

// File: rtl/duty_ramp.sv
// Soft-start/soft-stop duty sequencer: slews duty toward an accepted target by STEP every TICK_DIV cycles.
// Optional emergency stop is compiled in with `define DUTY_RAMP_ESTOP_EN.
module duty_ramp #(
    parameter int TICK_DIV = 50000,
    parameter int STEP     = 1,
    parameter int MAX_DUTY = 100
) (
    input  logic        clk_50,
    input  logic        rst_n,
    duty_ramp_if.slave  cmd,
    input  logic        estop,
    output logic [7:0]  duty,
    output logic        busy,
    output logic        done
);
    localparam int            CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [7:0]    STEP_B   = 8'(STEP);
    localparam logic [7:0]    MAX_B    = 8'(MAX_DUTY);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    duty_q, duty_d;
    logic [7:0]    target_q, target_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    logic          estop_active;
    logic          accept;
    logic [7:0]    tgt_req;
    logic [7:0]    diff;
    logic [7:0]    step_amt;
    logic          going_up;

`ifdef DUTY_RAMP_ESTOP_EN
    assign estop_active = estop;
`else
    logic unused_estop;
    assign unused_estop = estop;
    assign estop_active = 1'b0;
`endif

    assign cmd.cmd_ready = (state_q == IDLE) && !estop_active;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    // Clamped step: the last tick covers only what remains, so no overshoot and no wrap.
    assign tgt_req  = (cmd.cmd_duty > MAX_B) ? MAX_B : cmd.cmd_duty;
    assign going_up = duty_q < target_q;
    assign diff     = going_up ? (target_q - duty_q) : (duty_q - target_q);
    assign step_amt = (diff < STEP_B) ? diff : STEP_B;

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    target_d = tgt_req;
                    if (tgt_req == duty_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RAMP;
                    end
                end
            end
            RAMP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    duty_d = going_up ? (duty_q + step_amt) : (duty_q - step_amt);
                    if (step_amt == diff) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef DUTY_RAMP_ESTOP_EN
        if (estop) begin
            state_d  = IDLE;
            duty_d   = '0;
            target_d = '0;
            cnt_d    = '0;
            done_d   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            target_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign duty = duty_q;
    assign busy = (state_q == RAMP);
    assign done = done_q;
endmodule

// File: tb/tb_duty_ramp.sv
// Bench for duty_ramp: directed command sequence, a schedule-based reference model
// checked every cycle, and hand-computed pins on key edges.
module tb_duty_ramp;
    localparam int TD = 4;
    localparam int ST = 10;
    localparam int MX = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       estop = 1'b0;
    logic [7:0] duty;
    logic       busy;
    logic       done;

    duty_ramp_if bus ();

    duty_ramp #(.TICK_DIV(TD), .STEP(ST), .MAX_DUTY(MX)) dut (
        .clk_50 (clk),
        .rst_n  (rst_n),
        .cmd    (bus),
        .estop  (estop),
        .duty   (duty),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    logic estop_eff;
`ifdef DUTY_RAMP_ESTOP_EN
    assign estop_eff = estop;
`else
    assign estop_eff = 1'b0;
`endif

    // Reference model: the last accepted command and its edge index fully determine
    // the duty trajectory as a function of elapsed edges.
    int m_e = 0;
    bit m_have = 1'b0;
    int m_k = 0;
    int m_d0 = 0;
    int m_tgt = 0;
    int m_nt = 0;
    bit m_done_en = 1'b0;

    function automatic int m_duty(input int e);
        int s;
        int v;
        if (!m_have) return 0;
        s = (e - m_k) / TD;
        if (s < 0) s = 0;
        if (s > m_nt) s = m_nt;
        if (m_tgt >= m_d0) begin
            v = m_d0 + s * ST;
            if (v > m_tgt) v = m_tgt;
        end else begin
            v = m_d0 - s * ST;
            if (v < m_tgt) v = m_tgt;
        end
        return v;
    endfunction

    function automatic bit m_idle(input int e);
        return !m_have || (e >= m_k + m_nt * TD);
    endfunction

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have    <= 1'b0;
            m_done_en <= 1'b0;
        end else begin
            m_e <= m_e + 1;
            if (estop_eff) begin
                m_have    <= 1'b1;
                m_d0      <= 0;
                m_tgt     <= 0;
                m_k       <= m_e + 1;
                m_nt      <= 0;
                m_done_en <= 1'b0;
            end else if (m_idle(m_e) && bus.cmd_valid) begin
                m_have    <= 1'b1;
                m_d0      <= m_duty(m_e);
                m_tgt     <= (int'(bus.cmd_duty) > MX) ? MX : int'(bus.cmd_duty);
                m_k       <= m_e + 1;
                m_nt      <= (absdiff(((int'(bus.cmd_duty) > MX) ? MX : int'(bus.cmd_duty)),
                                      m_duty(m_e)) + ST - 1) / ST;
                m_done_en <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_duty",  int'(duty), m_duty(m_e));
        chk("model_busy",  int'(busy), int'(!m_idle(m_e)));
        chk("model_done",  int'(done), int'(m_have && m_done_en && (m_e == m_k + m_nt * TD)));
        chk("model_ready", int'(bus.cmd_ready), int'(m_idle(m_e) && !estop_eff));
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds cmd_valid until accepted; returns edges that passed without acceptance.
    task automatic send(input int v, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        @(negedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_duty  = 8'(v);
        for (int i = 0; i < 200 && !ok; i++) begin
            if (bus.cmd_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            if (!ok) waited++;
        end
        bus.cmd_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    int w;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_duty  = 8'd0;
        #12;
        chk("rst_duty", int'(duty), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(bus.cmd_ready), 1);
        #10 rst_n = 1'b1;

        // Ramp up 0 -> 50
        send(50, w);
        chk("up_busy_k1", int'(busy), 1);
        chk("up_duty_k1", int'(duty), 0);
        for (int i = 1; i <= 5; i++) begin
            edges(4);
            chk("up_duty_step", int'(duty), 10 * i);
        end
        chk("up_done", int'(done), 1);
        chk("up_busy_end", int'(busy), 0);
        chk("up_ready_end", int'(bus.cmd_ready), 1);
        edges(1);
        chk("up_done_once", int'(done), 0);

        // Partial step 50 -> 45
        send(45, w);
        edges(4);
        chk("partial_duty", int'(duty), 45);
        chk("partial_done", int'(done), 1);

        // Target equals duty
        send(45, w);
        chk("same_done", int'(done), 1);
        chk("same_busy", int'(busy), 0);
        edges(1);
        chk("same_done_once", int'(done), 0);

        // 45 -> 0, then clamp 200 -> 100
        send(0, w);
        edges(20);
        chk("down45_duty", int'(duty), 0);
        send(200, w);
        edges(36);
        chk("clamp_duty_9", int'(duty), 90);
        edges(4);
        chk("clamp_duty", int'(duty), 100);
        chk("clamp_done", int'(done), 1);

        // Ramp down 100 -> 0 with a 30 command held throughout
        send(0, w);
        send(30, w);
        chk("hold_waited", w, 40);
        chk("hold_duty_at_accept", int'(duty), 0);
        chk("hold_busy", int'(busy), 1);
        edges(12);
        chk("hold_duty_30", int'(duty), 30);

        // Reset mid-ramp at duty 30
        send(80, w);
        edges(2);
        chk("prerst_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_duty", int'(duty), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(bus.cmd_ready), 1);
        chk("arst_done", int'(done), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        edges(1);
        chk("postrst_done", int'(done), 0);

        // Estop mid-ramp at duty 40
        send(60, w);
        edges(16);
        chk("pre_estop_duty", int'(duty), 40);
        @(negedge clk);
        #1 estop = 1'b1;
        edges(1);
`ifdef DUTY_RAMP_ESTOP_EN
        chk("estop_duty", int'(duty), 0);
        chk("estop_ready", int'(bus.cmd_ready), 0);
        chk("estop_busy", int'(busy), 0);
`else
        chk("estop_ign_duty", int'(duty), 40);
        chk("estop_ign_busy", int'(busy), 1);
`endif
        edges(3);
        estop = 1'b0;
`ifdef DUTY_RAMP_ESTOP_EN
        chk("estop_hold_duty", int'(duty), 0);
`else
        chk("estop_ign_duty2", int'(duty), 50);
`endif
        edges(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
